// File: rtl/mbtrain_pkg.sv
// Shared MBTRAIN definitions: point-test state encoding, PRBS23 polynomial/seed,
// default lane count and a single-step PRBS23 helper.
package mbtrain_pkg;

  localparam int DEF_NUM_LANES = 16;

  // x^23 + x^18 + 1 expressed as a tap mask on state bits 22 and 17
  localparam logic [22:0] PRBS23_POLY = 23'h420000;
  localparam logic [22:0] PRBS23_SEED = 23'h1DBFBC;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CLEAR   = 3'd1;
  localparam logic [2:0] ST_COMPARE = 3'd2;
  localparam logic [2:0] ST_EVAL    = 3'd3;
  localparam logic [2:0] ST_ACK     = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    CLEAR   = ST_CLEAR,
    COMPARE = ST_COMPARE,
    EVAL    = ST_EVAL,
    ACK     = ST_ACK
  } pt_state_t;

  function automatic logic [22:0] prbs23_step(input logic [22:0] s);
    return {s[21:0], ^(s & PRBS23_POLY)};
  endfunction

endpackage

// File: rtl/mbtrain_rx_point_test_if.sv
// Controller-facing bus of the RX point-test engine. The debug counter vector
// o_err_cnt exists only when MBTRAIN_PT_ERR_CNT_OUT_EN is defined.
interface mbtrain_rx_point_test_if
  import mbtrain_pkg::*;
#(
  parameter int NUM_LANES = DEF_NUM_LANES,
  parameter int LANE_W    = 8
`ifdef MBTRAIN_PT_ERR_CNT_OUT_EN
  ,
  parameter int CNT_W     = 8
`endif
);

  logic                        i_en;
  logic [NUM_LANES*LANE_W-1:0] i_rx_data;
  logic                        i_rx_data_valid;
  logic                        o_test_ack;
  logic [NUM_LANES-1:0]        o_lanes_result;
  logic                        o_busy;

`ifdef MBTRAIN_PT_ERR_CNT_OUT_EN
  logic [NUM_LANES*CNT_W-1:0]  o_err_cnt;

  modport master (
    output i_en, i_rx_data, i_rx_data_valid,
    input  o_test_ack, o_lanes_result, o_busy, o_err_cnt
  );

  modport slave (
    input  i_en, i_rx_data, i_rx_data_valid,
    output o_test_ack, o_lanes_result, o_busy, o_err_cnt
  );
`else
  modport master (
    output i_en, i_rx_data, i_rx_data_valid,
    input  o_test_ack, o_lanes_result, o_busy
  );

  modport slave (
    input  i_en, i_rx_data, i_rx_data_valid,
    output o_test_ack, o_lanes_result, o_busy
  );
`endif

endinterface

// File: rtl/mbtrain_prbs_gen.sv
// PRBS23 pattern source: seed load plus advance-by-LANE_W-steps per enable.
// Shared between the RX checker and the TX pattern generator.
module mbtrain_prbs_gen
  import mbtrain_pkg::*;
#(
  parameter int          LANE_W = 8,
  parameter logic [22:0] SEED   = PRBS23_SEED
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              adv,
  output logic [LANE_W-1:0] pattern
);

  logic [22:0] lfsr_reg;
  logic [22:0] lfsr_next;

  always_comb begin
    lfsr_next = lfsr_reg;
    for (int i = 0; i < LANE_W; i++) begin
      lfsr_next = prbs23_step(lfsr_next);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_reg <= SEED;
    end else if (load) begin
      lfsr_reg <= SEED;
    end else if (adv) begin
      lfsr_reg <= lfsr_next;
    end
  end

  assign pattern = lfsr_reg[LANE_W-1:0];

endmodule

// File: rtl/mbtrain_rx_point_test.sv
// MBTRAIN receiver point-test engine: checks ITERATIONS valid beats per lane against
// PRBS23 and reports per-lane pass/fail. Optional macro MBTRAIN_PT_ERR_CNT_OUT_EN exposes counters.
module mbtrain_rx_point_test
  import mbtrain_pkg::*;
#(
  parameter int          NUM_LANES  = DEF_NUM_LANES,
  parameter int          LANE_W     = 8,
  parameter int          ITERATIONS = 64,
  parameter int          ERR_THRESH = 4,
  parameter int          CNT_W      = 8,
  parameter logic [22:0] LFSR_SEED  = PRBS23_SEED
) (
  input  logic                    clk,
  input  logic                    rst_n,
  mbtrain_rx_point_test_if.slave  bus
);

  localparam int                BEAT_W    = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
  localparam int                ERR_W     = $clog2(LANE_W + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  THRESH    = CNT_W'(ERR_THRESH);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(ITERATIONS - 1);

  pt_state_t            state_reg;
  logic [BEAT_W-1:0]    beat_reg;
  logic                 test_ack_reg;
  logic                 busy_reg;
  logic [NUM_LANES-1:0] result_reg;
  logic [NUM_LANES-1:0] pass_vec;
  logic [LANE_W-1:0]    pattern;
  logic                 clear_en;
  logic                 beat_en;

  assign clear_en = (state_reg == CLEAR);
  assign beat_en  = (state_reg == COMPARE) && bus.i_rx_data_valid;

  mbtrain_prbs_gen #(
    .LANE_W (LANE_W),
    .SEED   (LFSR_SEED)
  ) u_prbs (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (clear_en),
    .adv     (beat_en),
    .pattern (pattern)
  );

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    logic [CNT_W-1:0]  cnt_reg;
    logic [LANE_W-1:0] diff;
    logic [ERR_W-1:0]  errs;
    logic [CNT_W:0]    sum;

    always_comb begin
      diff = bus.i_rx_data[gi*LANE_W +: LANE_W] ^ pattern;
      errs = '0;
      for (int b = 0; b < LANE_W; b++) begin
        errs = errs + ERR_W'(diff[b]);
      end
      sum = {1'b0, cnt_reg} + (CNT_W+1)'(errs);
    end

    // Carry out of the counter width means saturate rather than wrap
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_reg <= '0;
      end else if (clear_en) begin
        cnt_reg <= '0;
      end else if (beat_en) begin
        cnt_reg <= sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
      end
    end

    assign pass_vec[gi] = (cnt_reg <= THRESH);

`ifdef MBTRAIN_PT_ERR_CNT_OUT_EN
    assign bus.o_err_cnt[gi*CNT_W +: CNT_W] = cnt_reg;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      beat_reg     <= '0;
      test_ack_reg <= 1'b0;
      busy_reg     <= 1'b0;
      result_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.i_en) begin
            state_reg <= CLEAR;
            busy_reg  <= 1'b1;
          end
        end
        CLEAR: begin
          // Result is cleared even on abort so an aborted test never shows stale passes
          result_reg <= '0;
          beat_reg   <= '0;
          if (!bus.i_en) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else begin
            state_reg <= COMPARE;
          end
        end
        COMPARE: begin
          if (!bus.i_en) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else if (bus.i_rx_data_valid) begin
            beat_reg <= beat_reg + 1'b1;
            if (beat_reg == LAST_BEAT) begin
              state_reg <= EVAL;
            end
          end
        end
        EVAL: begin
          busy_reg <= 1'b0;
          if (!bus.i_en) begin
            state_reg <= IDLE;
          end else begin
            result_reg   <= pass_vec;
            test_ack_reg <= 1'b1;
            state_reg    <= ACK;
          end
        end
        ACK: begin
          if (!bus.i_en) begin
            test_ack_reg <= 1'b0;
            state_reg    <= IDLE;
          end
        end
        default: begin
          state_reg    <= IDLE;
          test_ack_reg <= 1'b0;
          busy_reg     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_test_ack     = test_ack_reg;
  assign bus.o_lanes_result = result_reg;
  assign bus.o_busy         = busy_reg;

endmodule

// File: tb/tb_mbtrain_rx_point_test.sv
// Directed bench for mbtrain_rx_point_test: clean, threshold, gapped, saturation,
// reset, abort and ack-handshake cases against an independent PRBS23 model.
`timescale 1ns/1ps
module tb_mbtrain_rx_point_test;

  localparam int NL = 16;
  localparam int LW = 8;
  localparam int DW = NL * LW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mbtrain_rx_point_test_if bus ();

  mbtrain_rx_point_test dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          errors = 0;
  int          checks = 0;
  logic [22:0] lfsr_m;
  logic [DW-1:0] m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference PRBS23 (x^23+x^18+1), eight shifts per beat
  function automatic logic [22:0] model_step8(input logic [22:0] s);
    logic [22:0] t;
    t = s;
    for (int i = 0; i < 8; i++) t = {t[21:0], t[22] ^ t[17]};
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_test();
    bus.i_en = 1'b1;
    lfsr_m   = 23'h1DBFBC;
    tick();
    tick();
  endtask

  task automatic beat(input logic [DW-1:0] xmask);
    bus.i_rx_data       = {NL{lfsr_m[7:0]}} ^ xmask;
    bus.i_rx_data_valid = 1'b1;
    tick();
    bus.i_rx_data_valid = 1'b0;
    bus.i_rx_data       = {4{$urandom()}};
    lfsr_m              = model_step8(lfsr_m);
  endtask

  task automatic gap();
    bus.i_rx_data_valid = 1'b0;
    bus.i_rx_data       = {4{$urandom()}};
    tick();
  endtask

  // Called right after the edge that consumed the last beat
  task automatic finish_ack(input string tag);
    check({tag, "_ack_eval"}, bus.o_test_ack, 0);
    check({tag, "_busy_eval"}, bus.o_busy, 1);
    tick();
    check({tag, "_ack"}, bus.o_test_ack, 1);
    check({tag, "_busy_ack"}, bus.o_busy, 0);
  endtask

  initial begin
    bus.i_en            = 1'b0;
    bus.i_rx_data       = '0;
    bus.i_rx_data_valid = 1'b0;

    // Reset
    tick();
    tick();
    check("rst_ack", bus.o_test_ack, 0);
    check("rst_result", bus.o_lanes_result, 0);
    check("rst_busy", bus.o_busy, 0);
    rst_n = 1'b1;
    tick();
    $display("step reset: ack=%0b result=%h busy=%0b", bus.o_test_ack, bus.o_lanes_result, bus.o_busy);

    // Clean pass followed by the ack handshake
    start_test();
    check("clean_busy", bus.o_busy, 1);
    for (int b = 0; b < 64; b++) beat('0);
    finish_ack("clean");
    check("clean_result", bus.o_lanes_result, 16'hFFFF);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_ack", bus.o_test_ack, 1);
      check("hold_result", bus.o_lanes_result, 16'hFFFF);
    end
    bus.i_en = 1'b0;
    tick();
    check("drop_ack", bus.o_test_ack, 0);
    check("drop_busy", bus.o_busy, 0);
    check("idle_result", bus.o_lanes_result, 16'hFFFF);
    tick();
    check("idle_result2", bus.o_lanes_result, 16'hFFFF);
    $display("step clean+handshake: result=%h ack=%0b", bus.o_lanes_result, bus.o_test_ack);

    // Threshold boundary: lane 3 gets 4 errors, lane 9 gets 5
    start_test();
    check("clear_result", bus.o_lanes_result, 0);
    for (int b = 0; b < 64; b++) begin
      m = '0;
      if (b == 3 || b == 10 || b == 20 || b == 40) m[24 + (b % 8)] = 1'b1;
      if (b == 5 || b == 15 || b == 25 || b == 35 || b == 63) m[72 + (b % 8)] = 1'b1;
      beat(m);
    end
    finish_ack("thresh");
    check("thresh_result", bus.o_lanes_result, 16'hFDFF);
`ifdef MBTRAIN_PT_ERR_CNT_OUT_EN
    check("thresh_cnt3", bus.o_err_cnt[3*8 +: 8], 4);
    check("thresh_cnt9", bus.o_err_cnt[9*8 +: 8], 5);
    check("thresh_cnt0", bus.o_err_cnt[0 +: 8], 0);
`endif
    bus.i_en = 1'b0;
    tick();
    $display("step threshold: result=%h", bus.o_lanes_result);

    // Gapped valid with garbage on idle cycles
    start_test();
    for (int b = 0; b < 64; b++) begin
      int gaps;
      gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) gap();
      if (b == 63) begin
        check("gap_noack_early", bus.o_test_ack, 0);
        check("gap_busy_early", bus.o_busy, 1);
      end
      beat('0);
    end
    finish_ack("gap");
    check("gap_result", bus.o_lanes_result, 16'hFFFF);
    bus.i_en = 1'b0;
    tick();
    $display("step gapped: result=%h", bus.o_lanes_result);

    // Saturation: lanes 8..15 inverted on every beat
    start_test();
    m = {{64{1'b1}}, {64{1'b0}}};
    for (int b = 0; b < 64; b++) beat(m);
    finish_ack("sat");
    check("sat_result", bus.o_lanes_result, 16'h00FF);
`ifdef MBTRAIN_PT_ERR_CNT_OUT_EN
    check("sat_cnt8", bus.o_err_cnt[8*8 +: 8], 255);
    check("sat_cnt15", bus.o_err_cnt[15*8 +: 8], 255);
    check("sat_cnt7", bus.o_err_cnt[7*8 +: 8], 0);
`endif
    $display("step saturation: result=%h", bus.o_lanes_result);

    // Asynchronous reset while acknowledged, then while comparing
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ack", bus.o_test_ack, 0);
    check("arst_result", bus.o_lanes_result, 0);
    tick();
    rst_n = 1'b1;
    bus.i_en = 1'b0;
    tick();
    start_test();
    for (int b = 0; b < 5; b++) beat('0);
    check("mid_busy", bus.o_busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", bus.o_busy, 0);
    bus.i_en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    $display("step async reset: ack=%0b busy=%0b", bus.o_test_ack, bus.o_busy);

    // Abort at beat 30, then a clean restart from the seed
    start_test();
    for (int b = 0; b < 30; b++) beat('0);
    bus.i_en = 1'b0;
    tick();
    check("abort_busy", bus.o_busy, 0);
    check("abort_ack", bus.o_test_ack, 0);
    check("abort_result", bus.o_lanes_result, 0);
    tick();
    tick();
    check("abort_ack_late", bus.o_test_ack, 0);
    start_test();
    for (int b = 0; b < 64; b++) beat('0);
    finish_ack("restart");
    check("restart_result", bus.o_lanes_result, 16'hFFFF);
    bus.i_en = 1'b0;
    tick();
    check("restart_drop_ack", bus.o_test_ack, 0);
    $display("step abort+restart: result=%h", bus.o_lanes_result);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
